bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 21 ++
 rtl/bus_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// External memory bus between the arbiter (master) and the memory/bus fabric (slave).
// A transaction completes in the cycle where ext_req and ext_ack are both high.
interface bus_arbiter_if;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_wstrb;
  logic        ext_ack;
  logic [31:0] ext_rdata;

  modport master (
    output ext_req, ext_we, ext_addr, ext_wdata, ext_wstrb,
    input  ext_ack, ext_rdata
  );

  modport slave (
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_wstrb,
    output ext_ack, ext_rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one external bus between instruction fetch and data access,
// with byte/half/word lane steering for stores and extraction/extension for loads.
module bus_arbiter (
  input  logic          clk,
  input  logic          resetn,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  input  logic          fetch_flush,
  output logic [31:0]   fetch_data,
  output logic          fetch_ready,
  input  logic          data_load,
  input  logic          data_store,
  input  logic [31:0]   data_addr,
  input  logic [31:0]   data_store_data,
  input  logic [1:0]    data_size,
  input  logic          data_signed,
  output logic [31:0]   data_load_data,
  output logic          data_ready,
  bus_arbiter_if.master ext
);

  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D, RESP} state_t;
  typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t;

  state_t      state_q, state_d;
  grant_t      last_q, last_d;
  logic        flush_q, flush_d;
  logic        store_q, store_d;
  logic        signed_q, signed_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        fready_q, fready_d;
  logic        dready_q, dready_d;
  logic [31:0] fdata_q, fdata_d;
  logic [31:0] ldata_q, ldata_d;

  logic        fetch_pend, data_pend, grant_data, ack;
  logic [31:0] lane_data;
  logic [3:0]  lane_strb;
  logic        fetch_addr_unused;

  // Fetches are word aligned, so the low address bits carry no information.
  assign fetch_addr_unused = ^fetch_addr[1:0];

  assign fetch_pend = fetch_req && !fetch_flush;
  assign data_pend  = data_load || data_store;
  assign grant_data = data_pend && (!fetch_pend || last_q == GRANT_FETCH);
  assign ack        = req_q && ext.ext_ack;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    lane_data = data_store_data;
    lane_strb = 4'b1111;
    case (data_size)
      2'b00: begin
        lane_data = {4{data_store_data[7:0]}};
        lane_strb = 4'b0001 << data_addr[1:0];
      end
      2'b01: begin
        lane_data = {2{data_store_data[15:0]}};
        lane_strb = 4'b0011 << {data_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    flush_d  = flush_q;
    store_d  = store_q;
    signed_d = signed_q;
    size_d   = size_q;
    off_d    = off_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    fready_d = 1'b0;
    dready_d = 1'b0;
    fdata_d  = fdata_q;
    ldata_d  = ldata_q;
    unique case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (grant_data) begin
          state_d  = BUSY_D;
          last_d   = GRANT_DATA;
          req_d    = 1'b1;
          we_d     = data_store;
          addr_d   = {data_addr[31:2], 2'b00};
          wdata_d  = data_store ? lane_data : 32'h0;
          wstrb_d  = data_store ? lane_strb : 4'b0000;
          store_d  = data_store;
          signed_d = data_signed;
          size_d   = data_size;
          off_d    = data_addr[1:0];
        end else if (fetch_pend) begin
          state_d = BUSY_F;
          last_d  = GRANT_FETCH;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = {fetch_addr[31:2], 2'b00};
          wdata_d = 32'h0;
          wstrb_d = 4'b0000;
        end
      end
      BUSY_F: begin
        if (fetch_flush) flush_d = 1'b1;
        if (ack) begin
          state_d  = RESP;
          req_d    = 1'b0;
          flush_d  = 1'b0;
          fready_d = !(flush_q || fetch_flush);
          if (fready_d) fdata_d = ext.ext_rdata;
        end
      end
      BUSY_D: begin
        if (ack) begin
          state_d  = RESP;
          req_d    = 1'b0;
          we_d     = 1'b0;
          wstrb_d  = 4'b0000;
          dready_d = 1'b1;
          ldata_d  = store_q ? 32'h0 : extract(ext.ext_rdata, size_q, off_q, signed_q);
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      last_q   <= GRANT_FETCH;
      flush_q  <= 1'b0;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      off_q    <= 2'b00;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'b0000;
      fready_q <= 1'b0;
      dready_q <= 1'b0;
      fdata_q  <= 32'h0;
      ldata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      flush_q  <= flush_d;
      store_q  <= store_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      off_q    <= off_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      fready_q <= fready_d;
      dready_q <= dready_d;
      fdata_q  <= fdata_d;
      ldata_q  <= ldata_d;
    end
  end

  assign ext.ext_req    = req_q;
  assign ext.ext_we     = we_q;
  assign ext.ext_addr   = addr_q;
  assign ext.ext_wdata  = wdata_q;
  assign ext.ext_wstrb  = wstrb_q;
  // A flush landing in the response cycle itself still cancels the fetch delivery.
  assign fetch_ready    = fready_q && !fetch_flush;
  assign fetch_data     = fdata_q;
  assign data_ready     = dready_q;
  assign data_load_data = ldata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: reset, fetch, round-robin ties,
// store lanes, load extraction, flush handling and mid-transaction reset.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_req, fetch_flush, fetch_ready;
  logic [31:0] fetch_addr, fetch_data;
  logic        data_load, data_store, data_signed, data_ready;
  logic [31:0] data_addr, data_store_data, data_load_data;
  logic [1:0]  data_size;
  int          checks = 0;
  int          failures = 0;

  bus_arbiter_if bus ();

  bus_arbiter dut (
    .clk(clk), .resetn(resetn),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .data_load(data_load), .data_store(data_store), .data_addr(data_addr),
    .data_store_data(data_store_data), .data_size(data_size), .data_signed(data_signed),
    .data_load_data(data_load_data), .data_ready(data_ready),
    .ext(bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ack in the current cycle; on return the DUT is in its response cycle.
  task automatic ack_now(input logic [31:0] rd);
    bus.ext_ack   = 1'b1;
    bus.ext_rdata = rd;
    tick();
    bus.ext_ack   = 1'b0;
  endtask

  logic [31:0] ld_addr [5] = '{32'h2002, 32'h2001, 32'h2003, 32'h2000, 32'h2004};
  logic [1:0]  ld_size [5] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b11};
  logic        ld_sgn  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] ld_exp  [5] = '{32'hFFFF8001, 32'h00000012, 32'hFFFFFF80, 32'h00001234, 32'h80011234};

  logic [31:0] st_addr [4] = '{32'h1003, 32'h1002, 32'h1000, 32'h1008};
  logic [1:0]  st_size [4] = '{2'b00, 2'b01, 2'b00, 2'b10};
  logic [31:0] st_d    [4] = '{32'h000000A5, 32'h1234ABCD, 32'hFFFFFF5A, 32'h01234567};
  logic [31:0] st_ea   [4] = '{32'h1000, 32'h1000, 32'h1000, 32'h1008};
  logic [3:0]  st_strb [4] = '{4'b1000, 4'b1100, 4'b0001, 4'b1111};
  logic [31:0] st_wd   [4] = '{32'hA5A5A5A5, 32'hABCDABCD, 32'h5A5A5A5A, 32'h01234567};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    resetn = 1'b0;
    fetch_req = 0; fetch_addr = 0; fetch_flush = 0;
    data_load = 0; data_store = 0; data_addr = 0; data_store_data = 0;
    data_size = 0; data_signed = 0;
    bus.ext_ack = 0; bus.ext_rdata = 0;
    #3;
    check("rst_req", {31'h0, bus.ext_req}, 0);
    check("rst_we", {31'h0, bus.ext_we}, 0);
    check("rst_strb", {28'h0, bus.ext_wstrb}, 0);
    check("rst_addr", bus.ext_addr, 0);
    check("rst_wdata", bus.ext_wdata, 0);
    check("rst_fready", {31'h0, fetch_ready}, 0);
    check("rst_dready", {31'h0, data_ready}, 0);
    check("rst_fdata", fetch_data, 0);
    check("rst_ldata", data_load_data, 0);
    tick();
    resetn = 1'b1;

    // Fetch with ack in the third bus cycle.
    fetch_req = 1; fetch_addr = 32'h100;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.ext_req) n++;
      if (i == 0) begin
        check("f_addr", bus.ext_addr, 32'h100);
        check("f_we", {31'h0, bus.ext_we}, 0);
        check("f_strb", {28'h0, bus.ext_wstrb}, 0);
      end
    end
    ack_now(32'hDEADBEEF);
    check("f_req_cycles", n, 3);
    check("f_ready", {31'h0, fetch_ready}, 1);
    check("f_data", fetch_data, 32'hDEADBEEF);
    check("f_req_off", {31'h0, bus.ext_req}, 0);
    fetch_req = 0;
    tick();
    check("f_ready_off", {31'h0, fetch_ready}, 0);
    check("f_data_hold", fetch_data, 32'hDEADBEEF);

    // Ties from reset: data first, then alternate; minimum latency.
    resetn = 0; #2; resetn = 1;
    fetch_req = 1; fetch_addr = 32'h200;
    data_load = 1; data_addr = 32'h300; data_size = 2'b10;
    tick();
    check("tie1_addr", bus.ext_addr, 32'h300);
    ack_now(32'h11112222);
    check("tie1_dready", {31'h0, data_ready}, 1);
    check("tie1_fready", {31'h0, fetch_ready}, 0);
    check("tie1_ldata", data_load_data, 32'h11112222);
    tick();
    check("lat_idle_req", {31'h0, bus.ext_req}, 0);
    check("lat_idle_dready", {31'h0, data_ready}, 0);
    tick();
    check("tie2_req", {31'h0, bus.ext_req}, 1);
    check("tie2_addr", bus.ext_addr, 32'h200);
    ack_now(32'hCAFEF00D);
    check("tie2_fready", {31'h0, fetch_ready}, 1);
    check("tie2_fdata", fetch_data, 32'hCAFEF00D);
    tick(); tick();
    check("tie3_addr", bus.ext_addr, 32'h300);
    ack_now(32'h0);
    fetch_req = 0; data_load = 0;
    tick();

    // Loads: extraction and extension.
    for (int i = 0; i < 5; i++) begin
      data_load = 1; data_addr = ld_addr[i]; data_size = ld_size[i]; data_signed = ld_sgn[i];
      tick();
      check($sformatf("ld%0d_addr", i), bus.ext_addr, ld_addr[i] & ~32'h3);
      check($sformatf("ld%0d_strb", i), {28'h0, bus.ext_wstrb}, 0);
      ack_now(32'h80011234);
      check($sformatf("ld%0d_ready", i), {31'h0, data_ready}, 1);
      check($sformatf("ld%0d_data", i), data_load_data, ld_exp[i]);
      data_load = 0;
      tick();
    end

    // Stores: lane replication and strobes; first one also raises data_load.
    data_signed = 0;
    for (int i = 0; i < 4; i++) begin
      data_store = 1; data_load = (i == 0); data_addr = st_addr[i];
      data_size = st_size[i]; data_store_data = st_d[i];
      tick();
      check($sformatf("st%0d_we", i), {31'h0, bus.ext_we}, 1);
      check($sformatf("st%0d_addr", i), bus.ext_addr, st_ea[i]);
      check($sformatf("st%0d_strb", i), {28'h0, bus.ext_wstrb}, {28'h0, st_strb[i]});
      check($sformatf("st%0d_wdata", i), bus.ext_wdata, st_wd[i]);
      data_store = 0; data_load = 0; data_addr = 32'hFFFF_FFFF; data_store_data = 0;
      tick();
      check($sformatf("st%0d_stable", i), bus.ext_wdata, st_wd[i]);
      ack_now(32'h13572468);
      check($sformatf("st%0d_ready", i), {31'h0, data_ready}, 1);
      check($sformatf("st%0d_ldata", i), data_load_data, 0);
      tick();
    end

    // Flush in IDLE masks the fetch request for that cycle.
    fetch_req = 1; fetch_addr = 32'h400; fetch_flush = 1;
    tick();
    check("flidle_req", {31'h0, bus.ext_req}, 0);
    fetch_flush = 0;
    tick();
    check("flidle_grant", {31'h0, bus.ext_req}, 1);

    // Flush in BUSY_F: bus completes, no fetch_ready.
    fetch_flush = 1;
    tick();
    fetch_flush = 0; fetch_req = 0;
    check("flbusy_req", {31'h0, bus.ext_req}, 1);
    ack_now(32'h12345678);
    check("flbusy_fready", {31'h0, fetch_ready}, 0);
    check("flbusy_done", {31'h0, bus.ext_req}, 0);
    tick();

    // Flush in the fetch response cycle suppresses ready.
    fetch_req = 1; fetch_addr = 32'h404;
    tick();
    ack_now(32'h87654321);
    fetch_req = 0;
    check("flresp_before", {31'h0, fetch_ready}, 1);
    fetch_flush = 1;
    #1;
    check("flresp_fready", {31'h0, fetch_ready}, 0);
    fetch_flush = 0;
    tick();

    // Flush has no effect on data accesses.
    fetch_flush = 1; data_load = 1; data_addr = 32'h2000; data_size = 2'b10;
    tick();
    ack_now(32'h00000055);
    check("fldata_ready", {31'h0, data_ready}, 1);
    check("fldata_ldata", data_load_data, 32'h55);
    fetch_flush = 0; data_load = 0;
    tick();

    // Reset mid-transaction, then a late ack.
    fetch_req = 1; fetch_addr = 32'h500;
    tick();
    check("mrst_req_pre", {31'h0, bus.ext_req}, 1);
    #2 resetn = 0;
    #1;
    check("mrst_req", {31'h0, bus.ext_req}, 0);
    check("mrst_addr", bus.ext_addr, 0);
    fetch_req = 0;
    bus.ext_ack = 1; bus.ext_rdata = 32'hBAD0BAD0;
    #1 resetn = 1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (fetch_ready || data_ready || bus.ext_req) n++;
    end
    bus.ext_ack = 0;
    check("mrst_late_ack", n, 0);
    check("mrst_fdata", fetch_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
